shift_pipe_param: RTL

Parametrised successor to the team's two-stage blocking/non-blocking shift pair. It implements a DEPTH-stage, WIDTH-bit register chain with a runtime mode select. Staged mode behaves like the non-blocking chain: one stage per clock. Broadcast mode behaves like the collapsed blocking chain: every stage loads the input on the same edge. It adds per-stage valid tracking, enable/hold, flush and an occupancy count, and serves as the generic delay/alignment element in the 8-bit CPU datapath.

---
 rtl/shift_pipe_param.sv | 69 ++++++
 1 files changed

// File: rtl/shift_pipe_param.sv
// DEPTH-stage, WIDTH-bit register chain with per-stage valids.
// mode selects a staged shift (one stage per edge) or a broadcast load (all stages per edge).
module shift_pipe_param #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       mode,
  input  logic [WIDTH-1:0]           a,
  input  logic                       a_valid,
  output logic [WIDTH*DEPTH-1:0]     taps,
  output logic [DEPTH-1:0]           taps_valid,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int COUNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // No handshake: a/a_valid are consumed on every edge with en=1; there is no backpressure.
  // Data moves regardless of a_valid; valids are carried alongside, never gating loads.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      valid_q <= '0;
    end else if (en) begin
      if (mode) begin
        for (int k = 0; k < DEPTH; k++) begin
          stage_q[k] <= a;
          valid_q[k] <= a_valid;
        end
      end else begin
        stage_q[0] <= a;
        valid_q[0] <= a_valid;
        for (int k = 1; k < DEPTH; k++) begin
          stage_q[k] <= stage_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
      end
    end
  end

  always_comb begin
    taps = '0;
    for (int k = 0; k < DEPTH; k++) begin
      taps[k*WIDTH +: WIDTH] = stage_q[k];
    end
  end

  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count = count + COUNT_W'(valid_q[k]);
    end
  end

  assign taps_valid = valid_q;
  assign q          = stage_q[DEPTH-1];
  assign q_valid    = valid_q[DEPTH-1];

endmodule
